// File: rtl/llki_pkg.sv
// rtl/llki_pkg.sv - response record and address helpers for the scratchpad arbiter
// Purpose: response record carried through the per-requester FIFOs and the
//          byte-to-word address shift.
// Ports: none (package).
package llki_pkg;
  import top_pkg::*;

  localparam int unsigned WORD_SHIFT = 3;
  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned RSP_DEPTH  = 2;

  typedef struct packed {
    logic [TL_DW-1:0] rdata;
    logic             error;
  } rsp_t;
endpackage

// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - bus width defaults shared by the scratchpad slice
// Purpose: default data and address widths of the local interconnect.
// Ports: none (package).
package top_pkg;
  localparam int unsigned TL_DW = 64;
  localparam int unsigned TL_AW = 32;
endpackage

// File: rtl/prim_fifo_sync.sv
// rtl/prim_fifo_sync.sv - small synchronous FIFO with optional fall-through
// Purpose: Depth-entry FIFO; with Pass=1 a write into an empty FIFO is visible
//          on the read side in the same cycle.
// Ports: clk_i/rst_ni clock and sync active-low reset; wvalid_i/wdata_i write
//        side (caller never writes when full); rvalid_o/rready_i/rdata_o read
//        side; depth_o registered number of stored entries.
module prim_fifo_sync #(
  parameter int unsigned Width = 8,
  parameter bit          Pass  = 1'b1,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wvalid_i,
  input  logic [Width-1:0]           wdata_i,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] depth_o
);
  localparam int unsigned DepthW = $clog2(Depth + 1);

  logic [Width-1:0]  mem_q [Depth];
  logic [Width-1:0]  mem_d [Depth];
  logic [DepthW-1:0] count_q, count_d;
  logic [DepthW-1:0] wr_idx;
  logic              stored_valid, pop, pop_stored, push_stored;

  always_comb begin
    stored_valid = (count_q != '0);
    rvalid_o     = stored_valid | (Pass & wvalid_i);
    rdata_o      = stored_valid ? mem_q[0] : wdata_i;
    pop          = rvalid_o & rready_i;
    pop_stored   = pop & stored_valid;
    // A word that bypasses an empty FIFO and is consumed at once is never stored.
    push_stored  = wvalid_i & ~(pop & ~stored_valid) &
                   ((count_q < DepthW'(Depth)) | pop_stored);
    wr_idx       = count_q - DepthW'(pop_stored);
    mem_d        = mem_q;
    if (pop_stored) begin
      for (int k = 0; k < int'(Depth) - 1; k++) mem_d[k] = mem_q[k+1];
    end
    for (int k = 0; k < int'(Depth); k++) begin
      if (push_stored && wr_idx == DepthW'(k)) mem_d[k] = wdata_i;
    end
    count_d = count_q + DepthW'(push_stored) - DepthW'(pop_stored);
    depth_o = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: rtl/scratchpad_arbiter.sv
// rtl/scratchpad_arbiter.sv - two-requester round-robin front end for a scratchpad RAM
// Purpose: grants one of two requesters per cycle onto a single-port RAM,
//          flags out-of-range addresses, and returns responses in order
//          through a 2-entry fall-through FIFO per requester.
// Ports: clk_i/rst_ni clock and sync active-low reset; req_*_i[i] request
//        channel of requester i; rsp_*_i[i] response channel of requester i;
//        ram_* RAM access port (ram_rdata valid one cycle after ram_req).
module scratchpad_arbiter
  import llki_pkg::*;
#(
  parameter logic [31:0] ADDRESS = 32'h00000000,
  parameter logic [31:0] DEPTH   = 32'h00000100,
  parameter int unsigned DW      = top_pkg::TL_DW,
  parameter int unsigned AW      = top_pkg::TL_AW
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [1:0]                  req_valid_i,
  output logic [1:0]                  req_ready_i,
  input  logic [1:0]                  req_write_i,
  input  logic [1:0][AW-1:0]          req_addr_i,
  input  logic [1:0][DW-1:0]          req_wdata_i,
  input  logic [1:0][DW/8-1:0]        req_wmask_i,
  output logic [1:0]                  rsp_valid_i,
  input  logic [1:0]                  rsp_ready_i,
  output logic [1:0][DW-1:0]          rsp_rdata_i,
  output logic [1:0]                  rsp_error_i,
  output logic                        ram_req,
  output logic                        ram_write,
  output logic [$clog2(DEPTH/8)-1:0]  ram_addr,
  output logic [DW-1:0]               ram_wdata,
  output logic [DW-1:0]               ram_wmask,
  input  logic [DW-1:0]               ram_rdata
);
  localparam int unsigned RAM_AW = $clog2(DEPTH / 8);

  // last_q: requester granted most recently; reset to 1 so requester 0 wins first.
  logic last_q, last_d;
  logic infl_valid_q, infl_valid_d;
  logic infl_owner_q, infl_owner_d;
  logic infl_error_q, infl_error_d;
  logic infl_read_q, infl_read_d;

  logic [1:0]       eligible;
  logic             gnt_valid, gnt_idx;
  logic [AW-1:0]    offset;
  logic             in_range;
  rsp_t             push_data;
  logic [1:0]       push_valid, fifo_rvalid;
  rsp_t [1:0]       fifo_rdata;
  logic [1:0][1:0]  fifo_depth;

  // Next-state: eligibility from registered occupancy only, round-robin pick,
  // address decode and the in-flight record of the granted request.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eligible[i] = req_valid_i[i] &&
                    ((3'(fifo_depth[i]) +
                      3'(infl_valid_q && (infl_owner_q == 1'(i)))) < 3'd2);
    end
    gnt_valid = |eligible;
    gnt_idx   = (&eligible) ? ~last_q : eligible[1];
    last_d    = gnt_valid ? gnt_idx : last_q;

    offset   = req_addr_i[gnt_idx] - AW'(ADDRESS);
    in_range = (req_addr_i[gnt_idx] >= AW'(ADDRESS)) && (offset < AW'(DEPTH));

    infl_valid_d = gnt_valid;
    infl_owner_d = gnt_idx;
    infl_error_d = gnt_valid & ~in_range;
    infl_read_d  = gnt_valid & ~req_write_i[gnt_idx];
  end

  // Outputs: grant handshake, RAM strobe in the grant cycle, FIFO push one
  // cycle later. Everything is forced quiet while reset is asserted.
  always_comb begin
    req_ready_i = '0;
    ram_req     = 1'b0;
    ram_write   = 1'b0;
    if (rst_ni && gnt_valid) begin
      req_ready_i[gnt_idx] = 1'b1;
      ram_req              = in_range;
      ram_write            = in_range & req_write_i[gnt_idx];
    end
    ram_addr  = offset[WORD_SHIFT +: RAM_AW];
    ram_wdata = req_wdata_i[gnt_idx];
    for (int b = 0; b < int'(DW / 8); b++) begin
      ram_wmask[8*b +: 8] = {8{req_wmask_i[gnt_idx][b]}};
    end

    push_data.error = infl_error_q;
    push_data.rdata = (infl_read_q && !infl_error_q) ? ram_rdata : '0;
    push_valid[0]   = rst_ni & infl_valid_q & ~infl_owner_q;
    push_valid[1]   = rst_ni & infl_valid_q &  infl_owner_q;

    for (int i = 0; i < 2; i++) begin
      rsp_valid_i[i] = rst_ni & fifo_rvalid[i];
      rsp_rdata_i[i] = rsp_valid_i[i] ? fifo_rdata[i].rdata : '0;
      rsp_error_i[i] = rsp_valid_i[i] & fifo_rdata[i].error;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q       <= 1'b1;
      infl_valid_q <= 1'b0;
      infl_owner_q <= 1'b0;
      infl_error_q <= 1'b0;
      infl_read_q  <= 1'b0;
    end else begin
      last_q       <= last_d;
      infl_valid_q <= infl_valid_d;
      infl_owner_q <= infl_owner_d;
      infl_error_q <= infl_error_d;
      infl_read_q  <= infl_read_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    prim_fifo_sync #(
      .Width ($bits(rsp_t)),
      .Pass  (1'b1),
      .Depth (RSP_DEPTH)
    ) u_rsp_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wvalid_i (push_valid[i]),
      .wdata_i  (push_data),
      .rvalid_o (fifo_rvalid[i]),
      .rready_i (rsp_ready_i[i] & rst_ni),
      .rdata_o  (fifo_rdata[i]),
      .depth_o  (fifo_depth[i])
    );
  end
endmodule
